// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared definitions for the odd-even transposition sorter:
//                FSM state encoding and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sort_pkg;

    // FSM state encoding
    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_SORT   = 2'd1;
    localparam logic [1:0] S_UNLOAD = 2'd2;

    // Counter width for n items; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_swap.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_swap
//  Description : Combinational compare-exchange cell. lo is the word that
//                belongs at the lower index, hi the word for the higher index.
//                Equal words pass through unswapped.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_swap #(
    parameter int W       = 4,
    parameter int DESCEND = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic w_swap;

    // Swap only when the pair is strictly out of order for the chosen direction.
    always_comb begin
        w_swap = (DESCEND != 0) ? (a < b) : (a > b);
        lo     = w_swap ? b : a;
        hi     = w_swap ? a : b;
    end

endmodule
`default_nettype wire

// File: rtl/sortn_oddeven.sv
`default_nettype none
// ============================================================================
//  Module      : sortn_oddeven
//  Description : Sequential N-word sorter. Loads a frame over a valid/ready
//                stream, sorts it in place with N odd-even transposition
//                phases (one per cycle), then streams it out index 0 first.
//  Revision    : 1.0  initial release
// ============================================================================
module sortn_oddeven
    import sort_pkg::*;
#(
    parameter int W       = 4,
    parameter int N       = 8,
    parameter int DESCEND = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int              c_iw   = clog2_min1(N);
    localparam logic [c_iw-1:0] c_last = c_iw'(N - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_iw-1:0] r_idx;
    logic [c_iw-1:0] r_phase;
    logic [W-1:0]    r_arr  [N];
    logic [W-1:0]    w_even [N];
    logic [W-1:0]    w_odd  [N];
    logic            w_in_fire;
    logic            w_out_fire;

    assign w_in_fire  = (r_state == S_LOAD)   && in_valid;
    assign w_out_fire = (r_state == S_UNLOAD) && out_ready;

    // Even phase: pairs (0,1),(2,3)...
    for (genvar i = 0; i < N / 2; i++) begin : g_even
        cmp_swap #(.W(W), .DESCEND(DESCEND)) u_cs (
            .a  (r_arr[2*i]),
            .b  (r_arr[2*i+1]),
            .lo (w_even[2*i]),
            .hi (w_even[2*i+1])
        );
    end
    if (N % 2 == 1) begin : g_even_tail
        assign w_even[N-1] = r_arr[N-1];
    end

    // Odd phase: pairs (1,2),(3,4)...; element 0 is always unpaired.
    assign w_odd[0] = r_arr[0];
    for (genvar i = 0; i < (N - 1) / 2; i++) begin : g_odd
        cmp_swap #(.W(W), .DESCEND(DESCEND)) u_cs (
            .a  (r_arr[2*i+1]),
            .b  (r_arr[2*i+2]),
            .lo (w_odd[2*i+1]),
            .hi (w_odd[2*i+2])
        );
    end
    if (N % 2 == 0) begin : g_odd_tail
        assign w_odd[N-1] = r_arr[N-1];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: leave each state when its counter reaches N-1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:   if (w_in_fire && (r_idx == c_last))  w_state_nxt = S_SORT;
            S_SORT:   if (r_phase == c_last)               w_state_nxt = S_UNLOAD;
            S_UNLOAD: if (w_out_fire && (r_idx == c_last)) w_state_nxt = S_LOAD;
            default:  w_state_nxt = S_LOAD;
        endcase
    end

    // Counters and the word array: capture in LOAD, one phase per cycle in SORT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_phase <= '0;
            for (int k = 0; k < N; k++) begin
                r_arr[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_phase <= '0;
                    if (w_in_fire) begin
                        r_arr[r_idx] <= in_data;
                        r_idx        <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
                    end
                end
                S_SORT: begin
                    for (int k = 0; k < N; k++) begin
                        r_arr[k] <= r_phase[0] ? w_odd[k] : w_even[k];
                    end
                    r_phase <= (r_phase == c_last) ? '0 : r_phase + 1'b1;
                end
                S_UNLOAD: begin
                    if (w_out_fire) begin
                        r_idx <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_phase <= '0;
                end
            endcase
        end
    end

    // Stream outputs decode from registered state; data is zero outside UNLOAD.
    always_comb begin
        in_ready  = (r_state == S_LOAD);
        out_valid = (r_state == S_UNLOAD);
        busy      = (r_state == S_SORT) || (r_state == S_UNLOAD);
        out_data  = (r_state == S_UNLOAD) ? r_arr[r_idx] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sortn_oddeven.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sortn_oddeven
//  Description : Self-checking bench for sortn_oddeven. Four instances
//                (W4/N8 ascending, W4/N8 descending, W8/N5, W8/N2) share
//                one stimulus path selected by r_sel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sortn_oddeven;

    typedef struct {
        int               sel;
        int               n;
        logic [0:7][7:0]  din;
        logic [0:7][7:0]  dexp;
        int               stall;
        int               hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    int         r_sel;
    int         cyc = 0;
    int         nvec = 0;
    int         nerr = 0;

    logic [3:0] w_ir, w_ov, w_bz;
    logic [3:0] w_d0, w_d1;
    logic [7:0] w_d2, w_d3;
    logic       m_ir, m_ov, m_bz;
    logic [7:0] m_d;

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    sortn_oddeven #(.W(4), .N(8), .DESCEND(0)) u0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && r_sel == 0), .in_ready(w_ir[0]), .in_data(in_data[3:0]),
        .out_valid(w_ov[0]), .out_ready(out_ready && r_sel == 0), .out_data(w_d0), .busy(w_bz[0]));
    sortn_oddeven #(.W(4), .N(8), .DESCEND(1)) u1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && r_sel == 1), .in_ready(w_ir[1]), .in_data(in_data[3:0]),
        .out_valid(w_ov[1]), .out_ready(out_ready && r_sel == 1), .out_data(w_d1), .busy(w_bz[1]));
    sortn_oddeven #(.W(8), .N(5), .DESCEND(0)) u2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && r_sel == 2), .in_ready(w_ir[2]), .in_data(in_data),
        .out_valid(w_ov[2]), .out_ready(out_ready && r_sel == 2), .out_data(w_d2), .busy(w_bz[2]));
    sortn_oddeven #(.W(8), .N(2), .DESCEND(0)) u3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && r_sel == 3), .in_ready(w_ir[3]), .in_data(in_data),
        .out_valid(w_ov[3]), .out_ready(out_ready && r_sel == 3), .out_data(w_d3), .busy(w_bz[3]));

    // Route the selected instance's outputs to the checker.
    always_comb begin
        m_ir = w_ir[r_sel[1:0]];
        m_ov = w_ov[r_sel[1:0]];
        m_bz = w_bz[r_sel[1:0]];
        case (r_sel)
            0:       m_d = {4'h0, w_d0};
            1:       m_d = {4'h0, w_d1};
            2:       m_d = w_d2;
            default: m_d = w_d3;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (sel %0d, cycle %0d): got %0d, expected %0d", name, r_sel, cyc, act, exp);
        end
    endtask

    // Pulse reset one cycle and check the reset-state outputs the cycle after.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(m_ir), 1);
        chk("rst_out_valid", 32'(m_ov), 0);
        chk("rst_busy",      32'(m_bz), 0);
        chk("rst_out_data",  32'(m_d),  0);
        @(posedge clk); #1;
    endtask

    // Present n words; returns the cycle number of the last handshake.
    task automatic load(input int n, input logic [0:7][7:0] din, output int t_last);
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            int bound;
            bound    = 0;
            in_data  = din[i];
            in_valid = 1'b1;
            @(negedge clk);
            while (!m_ir && bound < 20) begin
                @(negedge clk);
                bound++;
            end
            if (!m_ir) chk("load_timeout", 0, 1);
            t_last = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Wait through SORT and accept m of n words, checking each cycle.
    task automatic unload(input int n, input int m, input logic [0:7][7:0] dexp,
                          input int stall, input int hold, input int t_last);
        int   k;
        int   bound;
        bit   first;
        bit   was_stall;
        logic [7:0] held;
        k = 0; bound = 0; first = 1'b1; was_stall = 1'b0; held = 8'h00;
        if (hold != 0) begin
            in_valid = 1'b1;
            in_data  = 8'h0A;
        end
        out_ready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (k < m && bound < 200) begin
            @(negedge clk);
            bound++;
            if (!m_ov) begin
                if (was_stall) chk("stall_valid_dropped", 0, 1);
                chk("sort_busy",     32'(m_bz), 1);
                chk("sort_in_ready", 32'(m_ir), 0);
                chk("sort_data_zero", 32'(m_d), 0);
            end else begin
                if (first) begin
                    chk("latency", 32'(cyc - t_last), 32'(n + 1));
                    first = 1'b0;
                end
                chk("out_data",        32'(m_d),  32'(dexp[k]));
                chk("unload_busy",     32'(m_bz), 1);
                chk("unload_in_ready", 32'(m_ir), 0);
                if (was_stall) chk("stall_hold", 32'(m_d), 32'(held));
                held = m_d;
                if (out_ready) begin
                    k++;
                    was_stall = 1'b0;
                end else begin
                    was_stall = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (k == m) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            if (stall != 0) out_ready = 1'($urandom_range(0, 1));
        end
        if (k < m) chk("unload_timeout", 32'(k), 32'(m));
        out_ready = 1'b1;
        if (m == n) begin
            // Back-to-back: the cycle after the last transfer is already LOAD.
            @(negedge clk);
            chk("b2b_in_ready",  32'(m_ir), 1);
            chk("b2b_out_valid", 32'(m_ov), 0);
            chk("b2b_busy",      32'(m_bz), 0);
            @(posedge clk); #1;
        end
    endtask

    vec_t vecs [9];

    initial begin
        int t_last;

        vecs[0] = '{0, 8, {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8},
                          {8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15}, 0, 0};
        vecs[1] = '{1, 8, {8'd3, 8'd7, 8'd3, 8'd0, 8'd15, 8'd7, 8'd0, 8'd3},
                          {8'd15, 8'd7, 8'd7, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0}, 0, 0};
        vecs[2] = '{0, 8, {8'd5, 8'd1, 8'd4, 8'd2, 8'd8, 8'd6, 8'd0, 8'd9},
                          {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9}, 1, 0};
        vecs[3] = '{0, 8, {8'd7, 8'd7, 8'd1, 8'd0, 8'd15, 8'd3, 8'd3, 8'd2},
                          {8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd7, 8'd7, 8'd15}, 0, 1};
        vecs[4] = '{0, 8, {8'd10, 8'd0, 8'd5, 8'd5, 8'd12, 8'd1, 8'd14, 8'd3},
                          {8'd0, 8'd1, 8'd3, 8'd5, 8'd5, 8'd10, 8'd12, 8'd14}, 0, 0};
        vecs[5] = '{2, 5, {8'd200, 8'd17, 8'd255, 8'd0, 8'd17, 8'd0, 8'd0, 8'd0},
                          {8'd0, 8'd17, 8'd17, 8'd200, 8'd255, 8'd0, 8'd0, 8'd0}, 0, 0};
        vecs[6] = '{3, 2, {8'd9, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                          {8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 0};
        vecs[7] = '{3, 2, {8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                          {8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 0};
        vecs[8] = '{1, 8, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
                          {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        r_sel     = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Table-driven frames.
        for (int v = 0; v < 9; v++) begin
            r_sel = vecs[v].sel;
            load(vecs[v].n, vecs[v].din, t_last);
            unload(vecs[v].n, vecs[v].n, vecs[v].dexp, vecs[v].stall, vecs[v].hold, t_last);
        end

        // Reset mid-load: partial frame is discarded.
        r_sel = 0;
        load(5, vecs[0].din, t_last);
        do_reset();
        load(8, vecs[4].din, t_last);
        unload(8, 8, vecs[4].dexp, 0, 0, t_last);

        // Reset mid-unload after three transfers.
        load(8, vecs[2].din, t_last);
        unload(8, 3, vecs[2].dexp, 0, 0, t_last);
        do_reset();
        load(8, vecs[3].din, t_last);
        unload(8, 8, vecs[3].dexp, 0, 0, t_last);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
